// File: rtl/garage_input_cond.sv
// garage_input_cond: synchronizes and debounces the door button and limit switches,
// then turns debounced button presses into lockout-guarded single-cycle Activate pulses.
module garage_input_cond #(
    parameter int DB_CYCLES      = 4,
    parameter int CNT_W          = 8,
    parameter int LOCKOUT_CYCLES = 8,
    parameter int LOCK_W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic up_sw_raw,
    input  logic dn_sw_raw,
    output logic Activate,
    output logic UP_Max,
    output logic DN_Max,
    output logic sw_fault
);
    localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES);
    localparam logic [LOCK_W-1:0] LOCK_END  = LOCK_W'(1);

    typedef enum logic {READY, LOCKOUT} state_t;

    // bit 0 = button, bit 1 = upper limit, bit 2 = lower limit
    logic [2:0]        s1_q, s2_q, stb_q, stb_d;
    logic [CNT_W-1:0]  cnt_q [3];
    logic [CNT_W-1:0]  cnt_d [3];
    logic              btn_prev_q;
    logic              rise;
    state_t            state_q, state_d;
    logic [LOCK_W-1:0] lock_q, lock_d;

    always_comb begin
        stb_d = stb_q;
        for (int k = 0; k < 3; k++) begin
            cnt_d[k] = (s2_q[k] == stb_q[k] || cnt_q[k] == DB_LAST) ? '0 : cnt_q[k] + 1'b1;
            stb_d[k] = (s2_q[k] != stb_q[k] && cnt_q[k] == DB_LAST) ? s2_q[k] : stb_q[k];
        end
    end

    assign UP_Max   = stb_q[1];
    assign DN_Max   = stb_q[2];
    assign sw_fault = UP_Max & DN_Max;
    assign rise     = stb_q[0] & ~btn_prev_q;

    // An edge arriving while in LOCKOUT, including its final cycle, is dropped.
    always_comb begin
        state_d  = state_q;
        lock_d   = lock_q;
        Activate = 1'b0;
        if (state_q == READY) begin
            if (rise && !sw_fault) begin
                Activate = 1'b1;
                lock_d   = LOCK_LOAD;
                state_d  = LOCKOUT;
            end
        end else begin
            lock_d  = lock_q - 1'b1;
            state_d = (lock_q == LOCK_END) ? READY : LOCKOUT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            stb_q      <= '0;
            for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
            btn_prev_q <= 1'b0;
            state_q    <= READY;
            lock_q     <= '0;
        end else begin
            s1_q       <= {dn_sw_raw, up_sw_raw, btn_raw};
            s2_q       <= s1_q;
            stb_q      <= stb_d;
            for (int k = 0; k < 3; k++) cnt_q[k] <= cnt_d[k];
            btn_prev_q <= stb_q[0];
            state_q    <= state_d;
            lock_q     <= lock_d;
        end
    end
endmodule

// File: doc/garage_input_cond.md
GARAGE_INPUT_COND -- requirements
Module: garage_input_cond

Interface
REQ-001 Parameter: DB_CYCLES, default 4, consecutive sampled cycles a differing input must hold before its debounced level changes.
REQ-002 Parameter: CNT_W, default 8, width of each debounce counter.
REQ-003 Parameter: LOCKOUT_CYCLES, default 8, cycles after an Activate pulse during which new presses are ignored.
REQ-004 Parameter: LOCK_W, default 8, width of the lockout counter.
REQ-005 Port: clk, input, 1, system clock; all state updates on the rising edge.
REQ-006 Port: rst, input, 1, reset, asynchronous, active-low.
REQ-007 Port: btn_raw, input, 1, raw door push-button, asynchronous to clk, active-high, may bounce.
REQ-008 Port: up_sw_raw, input, 1, raw upper limit switch, asynchronous, active-high, may bounce.
REQ-009 Port: dn_sw_raw, input, 1, raw lower limit switch, asynchronous, active-high, may bounce.
REQ-010 Port: Activate, output, 1, single-cycle command pulse to the door controller FSM.
REQ-011 Port: UP_Max, output, 1, debounced upper-limit level.
REQ-012 Port: DN_Max, output, 1, debounced lower-limit level.
REQ-013 Port: sw_fault, output, 1, high while UP_Max and DN_Max are both high.

Function
REQ-014 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 Each input SHALL have its own debouncer: a stable register plus a CNT_W-bit counter.
REQ-016 The counter SHALL clear on any cycle where the synchronized value equals the stable value.
REQ-017 The counter SHALL increment on each cycle where the synchronized value differs from the stable value.
REQ-018 The stable value SHALL take the synchronized value, and the counter SHALL clear, on the edge that completes DB_CYCLES consecutive differing samples.
REQ-019 Raw-to-stable latency SHALL be exactly 2 + DB_CYCLES clocks for a clean transition; any glitch shorter than DB_CYCLES samples SHALL have no effect.
REQ-020 UP_Max and DN_Max SHALL be the registered stable values of the upper and lower limit-switch inputs.
REQ-021 sw_fault SHALL equal UP_Max AND DN_Max, decoded from registers with no added latency.
REQ-022 Button handling SHALL be a 2-state FSM: READY and LOCKOUT.
REQ-023 In READY, a rising edge of the debounced button (stable 0->1) with sw_fault=0 SHALL assert Activate for one cycle, load the lockout counter with LOCKOUT_CYCLES, and move the FSM to LOCKOUT.
REQ-024 In READY, a rising edge of the debounced button while sw_fault=1 SHALL be discarded: no pulse, no state change.
REQ-025 In LOCKOUT, the lockout counter SHALL decrement each cycle, and the FSM SHALL return to READY on the cycle the count reaches 0.
REQ-026 Rising edges during LOCKOUT SHALL be ignored, not queued.
REQ-027 A held button SHALL produce exactly one pulse; a new pulse SHALL require a debounced release followed by a new press.
REQ-028 Activate SHALL never be high on two consecutive cycles.
REQ-029 When a rising edge and lockout expiry fall on the same cycle, the edge SHALL be ignored.
REQ-030 Legal parameter values: DB_CYCLES >= 2 and < 2^CNT_W; LOCKOUT_CYCLES >= 1 and < 2^LOCK_W.

Reset
REQ-031 On rst low, all of the following SHALL clear immediately, independent of clk: synchronizers, stable registers, counters, lockout counter; the FSM SHALL go to READY; Activate, UP_Max, DN_Max and sw_fault SHALL go to 0.
REQ-032 Reset asserted mid-debounce or mid-lockout SHALL discard all progress; after release, every input SHALL require a full 2 + DB_CYCLES clocks again.
REQ-033 A button held through reset release SHALL produce one Activate pulse 2 + DB_CYCLES clocks after release.

Verification (DB_CYCLES=4, LOCKOUT_CYCLES=8)
REQ-034 Clean press: btn_raw 0->1 held 30 cycles -> Activate high exactly one cycle, 6 clocks after the first sampling edge; no further pulse.
REQ-035 Bounce: btn_raw toggles every 2 cycles for 12 cycles, then holds 1 -> exactly one pulse, 6 clocks after the final rise.
REQ-036 Lockout: press, release, and re-press debounced within 8 cycles of the pulse -> no second pulse; re-press after expiry -> one pulse.
REQ-037 Fault: up_sw_raw=dn_sw_raw=1 -> UP_Max, DN_Max and sw_fault high after 6 clocks; a subsequent button press -> Activate stays 0.
REQ-038 Limit glitch: dn_sw_raw high for 3 cycles, then low -> DN_Max stays 0 throughout.
REQ-039 Reset mid-operation: rst low 3 cycles into a debounce of up_sw_raw=1 -> outputs 0 immediately; after release with input still 1 -> UP_Max rises 6 clocks later.
